// File: rtl/mult_pipe_param.sv
// mult_pipe_param: pipelined shift-add multiplier with a valid/ready handshake.
// Each of the STAGES stages consumes WIDTH/STAGES multiplier bits. Stalls propagate
// backwards through a combinational ready chain, and empty stages (bubbles) are refilled.
// Returns the full 2*WIDTH product together with an opaque caller tag.
// Optional feature: define MULT_PIPE_SIGNED_EN to add the in_signed port.
// Each operation then chooses two's-complement or unsigned arithmetic.
module mult_pipe_param #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 8,
  parameter int TAG_W  = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_mcand,
  input  logic [WIDTH-1:0]            in_mplier,
  input  logic [TAG_W-1:0]            in_tag,
`ifdef MULT_PIPE_SIGNED_EN
  input  logic                        in_signed,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*WIDTH-1:0]          out_product,
  output logic [TAG_W-1:0]            out_tag,
  output logic [$clog2(STAGES+1)-1:0] occupancy
);

  localparam int PW    = 2 * WIDTH;          // product / partial-sum width
  localparam int B     = WIDTH / STAGES;     // multiplier bits consumed per stage
  localparam int OCC_W = $clog2(STAGES + 1);

  if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0) || (TAG_W < 1)) begin : g_param_check
    $error("mult_pipe_param: need 1 <= STAGES <= WIDTH, WIDTH a multiple of STAGES, TAG_W >= 1");
  end

  logic [STAGES-1:0] valid_vec;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    // The multiplier operand shrinks by B bits per stage; SW is the width entering stage gi.
    localparam int SW = WIDTH - gi * B;

    logic             valid_reg;
    logic [PW-1:0]    sum_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             adv;          // stage gi can take new contents this cycle

    logic             src_valid;
    logic [PW-1:0]    src_sum;
    logic [PW-1:0]    src_mcand;
    logic [SW-1:0]    src_mplier;
    logic [TAG_W-1:0] src_tag;
    logic [B-1:0]     chunk;
    logic [PW-1:0]    base_pp;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    sum_next;
`ifdef MULT_PIPE_SIGNED_EN
    logic             src_sgn;
`endif

    // Source of this stage: the input ports for stage 0, otherwise the previous stage.
    if (gi == 0) begin : g_src
      assign src_valid  = in_valid;
      assign src_sum    = '0;
      assign src_mplier = in_mplier;
      assign src_tag    = in_tag;
`ifdef MULT_PIPE_SIGNED_EN
      assign src_sgn    = in_signed;
      assign src_mcand  = in_signed ? {{WIDTH{in_mcand[WIDTH-1]}}, in_mcand}
                                    : {{WIDTH{1'b0}}, in_mcand};
`else
      assign src_mcand  = {{WIDTH{1'b0}}, in_mcand};
`endif
    end else begin : g_src
      assign src_valid  = g_stage[gi-1].valid_reg;
      assign src_sum    = g_stage[gi-1].sum_reg;
      assign src_mplier = g_stage[gi-1].g_mid.mplier_reg;
      assign src_tag    = g_stage[gi-1].tag_reg;
      assign src_mcand  = g_stage[gi-1].g_mid.mcand_reg;
`ifdef MULT_PIPE_SIGNED_EN
      assign src_sgn    = g_stage[gi-1].g_mid.sgn_reg;
`endif
    end

    // Ready chain: a stage accepts when empty or when its contents move on.
    // The downstream stage decides whether they can move.
    if (gi == STAGES - 1) begin : g_adv
      assign adv = ~valid_reg | out_ready;
    end else begin : g_adv
      assign adv = ~valid_reg | g_stage[gi+1].adv;
    end

    assign chunk   = src_mplier[B-1:0];
    assign base_pp = src_mcand * {{(PW-B){1'b0}}, chunk};

    // The last stage holds the multiplier MSB. For signed ops that bit weighs -2^(WIDTH-1).
    // base_pp counted it as +2^(B-1) in the chunk, so 2^B * mcand is taken back off.
    if (gi == STAGES - 1) begin : g_pp
`ifdef MULT_PIPE_SIGNED_EN
      assign pp = (src_sgn && chunk[B-1]) ? (base_pp - (src_mcand << B)) : base_pp;
`else
      assign pp = base_pp;
`endif
    end else begin : g_pp
      assign pp = base_pp;
    end

    assign sum_next       = src_sum + pp;
    assign valid_vec[gi]  = valid_reg;

    // Valid, partial sum and tag advance together; data is captured only for real ops.
    // This keeps the output stable while the pipeline is empty.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_reg <= 1'b0;
        sum_reg   <= '0;
        tag_reg   <= '0;
      end else if (adv) begin
        valid_reg <= src_valid;
        if (src_valid) begin
          sum_reg <= sum_next;
          tag_reg <= src_tag;
        end
      end
    end

    // Intermediate stages also carry the shifted multiplicand and the remaining multiplier bits.
    if (gi < STAGES - 1) begin : g_mid
      logic [PW-1:0]   mcand_reg;
      logic [SW-B-1:0] mplier_reg;
`ifdef MULT_PIPE_SIGNED_EN
      logic            sgn_reg;
`endif

      // Operand registers for the next stage's step.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          mcand_reg  <= '0;
          mplier_reg <= '0;
`ifdef MULT_PIPE_SIGNED_EN
          sgn_reg    <= 1'b0;
`endif
        end else if (adv && src_valid) begin
          mcand_reg  <= src_mcand << B;
          mplier_reg <= src_mplier[SW-1:B];
`ifdef MULT_PIPE_SIGNED_EN
          sgn_reg    <= src_sgn;
`endif
        end
      end
    end
  end

  // Occupancy is the number of live stages.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(valid_vec[i]);
    end
  end

  assign in_ready    = g_stage[0].adv & reset;
  assign out_valid   = g_stage[STAGES-1].valid_reg;
  assign out_product = g_stage[STAGES-1].sum_reg;
  assign out_tag     = g_stage[STAGES-1].tag_reg;

endmodule

// File: tb/tb_mult_pipe_param.sv
// Directed testbench for mult_pipe_param (WIDTH=64, STAGES=8, TAG_W=4).
// It also covers STAGES=1 and STAGES=64 instances.
// Signed cases are exercised when MULT_PIPE_SIGNED_EN is defined.
module tb_mult_pipe_param;

  localparam int W = 64;
  localparam int T = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_mcand = '0;
  logic [W-1:0]   in_mplier = '0;
  logic [T-1:0]   in_tag = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] out_product;
  logic [T-1:0]   out_tag;
  logic [3:0]     occupancy;
`ifdef MULT_PIPE_SIGNED_EN
  logic           in_signed = 1'b0;
`endif

  // Shared stimulus for the STAGES=1 / STAGES=64 variants
  logic           v_valid = 1'b0;
  logic [W-1:0]   v_mcand = '0;
  logic [W-1:0]   v_mplier = '0;
  logic [T-1:0]   v_tag = '0;
  logic           v1_in_ready, v1_out_valid, v64_in_ready, v64_out_valid;
  logic [2*W-1:0] v1_out_product, v64_out_product;
  logic [T-1:0]   v1_out_tag, v64_out_tag;
  logic [0:0]     v1_occupancy;
  logic [6:0]     v64_occupancy;

  always #5 clk = ~clk;

  mult_pipe_param #(.WIDTH(W), .STAGES(8), .TAG_W(T)) u_dut (
    .clock(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mcand(in_mcand), .in_mplier(in_mplier), .in_tag(in_tag),
`ifdef MULT_PIPE_SIGNED_EN
    .in_signed(in_signed),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag), .occupancy(occupancy)
  );

  mult_pipe_param #(.WIDTH(W), .STAGES(1), .TAG_W(T)) u_s1 (
    .clock(clk), .reset(rst_n),
    .in_valid(v_valid), .in_ready(v1_in_ready),
    .in_mcand(v_mcand), .in_mplier(v_mplier), .in_tag(v_tag),
`ifdef MULT_PIPE_SIGNED_EN
    .in_signed(1'b0),
`endif
    .out_valid(v1_out_valid), .out_ready(1'b1),
    .out_product(v1_out_product), .out_tag(v1_out_tag), .occupancy(v1_occupancy)
  );

  mult_pipe_param #(.WIDTH(W), .STAGES(64), .TAG_W(T)) u_s64 (
    .clock(clk), .reset(rst_n),
    .in_valid(v_valid), .in_ready(v64_in_ready),
    .in_mcand(v_mcand), .in_mplier(v_mplier), .in_tag(v_tag),
`ifdef MULT_PIPE_SIGNED_EN
    .in_signed(1'b0),
`endif
    .out_valid(v64_out_valid), .out_ready(1'b1),
    .out_product(v64_out_product), .out_tag(v64_out_tag), .occupancy(v64_occupancy)
  );

  typedef struct {
    logic [2*W-1:0] prod;
    logic [T-1:0]   tag;
    int             cyc;
  } exp_t;

  exp_t           sb[$];
  logic [2*W-1:0] cur_exp = '0;
  int             cyc = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  int             n_emit = 0;
  int             n_acc = 0;
  bit             chk_lat = 1'b0;
  bit             chk_rdy = 1'b0;
  localparam int  LAT = 8;

  task automatic chk(input string name, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock cycle. Handshakes are sampled mid-cycle and the scoreboard is updated.
  // Then step to 1 time unit after the next rising edge.
  task automatic cycle();
    exp_t e;
    #2;
    if (chk_rdy && in_valid) chk("in_ready_b2b", 128'(in_ready), 128'(1));
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("product", out_product, e.prod);
        chk("tag", 128'(out_tag), 128'(e.tag));
        if (chk_lat) chk("latency", 128'(cyc - e.cyc), 128'(LAT));
      end
      n_emit++;
    end
    if (in_valid && in_ready) begin
      e.prod = cur_exp;
      e.tag  = in_tag;
      e.cyc  = cyc;
      sb.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int target, input int bound);
    int k = 0;
    while (n_emit < target && k < bound) begin
      cycle();
      k++;
    end
    chk("drain_count", 128'(n_emit), 128'(target));
  endtask

  task automatic set_op(input int j);
    in_valid  = 1'b1;
    in_mcand  = 64'h0123_4567_89AB_CDEF + 64'(j);
    in_mplier = 64'hFEDC_0000_0000_1000 - 64'(j);
    in_tag    = 4'(j);
`ifdef MULT_PIPE_SIGNED_EN
    in_signed = 1'b0;
`endif
    cur_exp   = 128'(in_mcand) * 128'(in_mplier);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int j;
    int prev;
    int base;
    int f1;
    int f64;
    logic [2*W-1:0] held;
    logic [2*W-1:0] p1;
    logic [2*W-1:0] p64;

    // Reset state while reset is held low
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_out_product", out_product, 128'(0));
    chk("rst_out_tag", 128'(out_tag), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Test 1: 3*5, tag 2, latency 8
    chk_lat   = 1'b1;
    in_valid  = 1'b1;
    in_mcand  = 64'd3;
    in_mplier = 64'd5;
    in_tag    = 4'd2;
    cur_exp   = 128'd15;
    cycle();
    in_valid = 1'b0;
    drain(1, 20);
    chk("t1_occ_empty", 128'(occupancy), 128'(0));
    chk("t1_out_valid_low", 128'(out_valid), 128'(0));

    // Test 2: 20 back-to-back random ops
    chk_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid  = 1'b1;
      in_mcand  = {$urandom, $urandom};
      in_mplier = {$urandom, $urandom};
      in_tag    = 4'(i);
      cur_exp   = 128'(in_mcand) * 128'(in_mplier);
      cycle();
    end
    in_valid = 1'b0;
    chk_rdy  = 1'b0;
    drain(21, 30);

    // Test 3: all-ones squared, unsigned
    in_valid  = 1'b1;
    in_mcand  = '1;
    in_mplier = '1;
    in_tag    = 4'hA;
    cur_exp   = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    cycle();
    in_valid = 1'b0;
    drain(22, 20);

    // Test 4: consumer stalled while 10 ops are offered
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    j = 0;
    for (int c = 0; c < 14; c++) begin
      set_op(j);
      prev = n_acc;
      cycle();
      if (n_acc != prev) j++;
    end
    chk("t4_accepts", 128'(j), 128'(8));
    chk("t4_occ_full", 128'(occupancy), 128'(8));
    chk("t4_in_ready_full", 128'(in_ready), 128'(0));
    held = out_product;
    cycle();
    cycle();
    cycle();
    chk("t4_out_valid_held", 128'(out_valid), 128'(1));
    chk("t4_hold_stable", out_product, held);
    chk("t4_hold_head", out_product, sb[0].prod);
    out_ready = 1'b1;
    #1;
    chk("t4_ready_full_drain", 128'(in_ready), 128'(1));
    prev = n_acc;
    cycle();
    if (n_acc != prev) j++;
    chk("t4_occ_swap", 128'(occupancy), 128'(8));
    for (int c = 0; c < 40 && (j < 10 || n_emit < 32); c++) begin
      if (j < 10) set_op(j);
      else in_valid = 1'b0;
      prev = n_acc;
      cycle();
      if (n_acc != prev) j++;
    end
    in_valid = 1'b0;
    chk("t4_emitted", 128'(n_emit), 128'(32));

    // Test 5: reset with 5 ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_op(20 + i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (8) cycle();
    chk("t5_occ_collapsed", 128'(occupancy), 128'(5));
    chk("t5_out_valid_pre", 128'(out_valid), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 128'(out_valid), 128'(0));
    chk("t5_rst_occupancy", 128'(occupancy), 128'(0));
    chk("t5_rst_in_ready", 128'(in_ready), 128'(0));
    chk("t5_rst_product", out_product, 128'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    base      = n_emit;
    repeat (15) cycle();
    chk("t5_no_stale", 128'(n_emit), 128'(base));

`ifdef MULT_PIPE_SIGNED_EN
    // Test 6: signed ops interleaved with an unsigned one
    chk_lat   = 1'b1;
    in_valid  = 1'b1;
    in_signed = 1'b1;
    in_mcand = '1; in_mplier = '1; in_tag = 4'd1; cur_exp = 128'd1;
    cycle();
    in_mcand = '1; in_mplier = 64'd2; in_tag = 4'd2;
    cur_exp = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
    cycle();
    in_mcand = 64'h8000_0000_0000_0000; in_mplier = 64'h8000_0000_0000_0000; in_tag = 4'd3;
    cur_exp = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
    cycle();
    in_signed = 1'b0;
    in_mcand = '1; in_mplier = '1; in_tag = 4'd4;
    cur_exp = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    cycle();
    in_signed = 1'b1;
    in_mcand = 64'hFFFF_FFFF_FFFF_FFFD; in_mplier = 64'd5; in_tag = 4'd5;
    cur_exp = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1;
    cycle();
    in_valid  = 1'b0;
    in_signed = 1'b0;
    drain(n_emit + 5, 20);
`endif

    // STAGES=1 and STAGES=64 variants of the all-ones square
    v_valid  = 1'b1;
    v_mcand  = '1;
    v_mplier = '1;
    v_tag    = 4'h5;
    #2;
    chk("v1_in_ready", 128'(v1_in_ready), 128'(1));
    chk("v64_in_ready", 128'(v64_in_ready), 128'(1));
    @(posedge clk);
    #1;
    v_valid = 1'b0;
    f1 = 0; f64 = 0; p1 = '0; p64 = '0;
    for (int n = 1; n <= 80 && (f1 == 0 || f64 == 0); n++) begin
      #2;
      if (v1_out_valid && f1 == 0) begin f1 = n; p1 = v1_out_product; end
      if (v64_out_valid && f64 == 0) begin f64 = n; p64 = v64_out_product; end
      @(posedge clk);
      #1;
    end
    chk("s1_latency", 128'(f1), 128'(1));
    chk("s1_product", p1, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    chk("s64_latency", 128'(f64), 128'(64));
    chk("s64_product", p64, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
